// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA text-mode geometry constants and the tile-map address helper
package vga_pkg;
  localparam int H_VISIBLE    = 640;
  localparam int V_VISIBLE    = 480;
  localparam int GLYPH_W      = 16;
  localparam int PIPE_DELAY   = 4;
  localparam int TILE_ADDR_W  = 11;
  localparam int GLYPH_ADDR_W = 17;
  // row*40 + col built from shifts; visible maximum 29*40+39 = 1199 fits 11 bits
  function automatic logic [TILE_ADDR_W-1:0] tile_index(input logic [5:0] row, input logic [5:0] col);
    logic [TILE_ADDR_W-1:0] r;
    r = TILE_ADDR_W'(row);
    return (r << 5) + (r << 3) + TILE_ADDR_W'(col);
  endfunction
endpackage

// File: rtl/sideband_delay.sv
// sideband_delay: W-bit wide, D-deep shift register with a per-bit reset value
module sideband_delay #(
  parameter int W = 1,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W*D-1:0] sr_q;
  // shift one slot per clock; reset loads every slot with the idle value
  always_ff @(posedge clk)
    sr_q <= reset ? {D{rst_val_i}} : {sr_q[W*(D-1)-1:0], d_i};
  assign q_o = sr_q[W*D-1 -: W];
endmodule

// File: rtl/glyph_fetch.sv
// glyph_fetch: tile-map lookup and glyph_rom address stage with aligned sync/active/cursor flags
module glyph_fetch
  import vga_pkg::*;
#(
  parameter int H_TILES      = 40,
  parameter int V_TILES      = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  input  logic                    active_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    cursor_en,
  input  logic [5:0]              cursor_col,
  input  logic [4:0]              cursor_row,
  output logic [TILE_ADDR_W-1:0]  tile_addr,
  input  logic [7:0]              tile_data,
  output logic [GLYPH_ADDR_W-1:0] glyph_addr,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    active_out,
  output logic                    cursor_hit
);
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  logic                    act_d, hit_d, wrap;
  logic                    act1_q, act2_q, vs_q, blink_on_q;
  logic [CW-1:0]           frame_q;
  logic [7:0]              px1_q, px2_q;
  logic [TILE_ADDR_W-1:0]  tile_addr_d, tile_addr_q;
  logic [GLYPH_ADDR_W-1:0] glyph_addr_d, glyph_addr_q;
  // qualify the pixel, match the cursor cell and form both addresses; inactive pixels use blank glyph 0
  always_comb begin
    act_d        = active_in && (hcount < 10'(H_TILES * GLYPH_W)) && (vcount < 10'(V_TILES * GLYPH_W));
    hit_d        = act_d && cursor_en && blink_on_q && hcount[9:4] == cursor_col && vcount[9:4] == {1'b0, cursor_row};
    tile_addr_d  = act_d ? tile_index(vcount[9:4], hcount[9:4]) : '0;
    glyph_addr_d = act2_q ? {1'b0, tile_data, px2_q} : '0;
    wrap         = frame_q == CW'(BLINK_FRAMES - 1);
  end
  // address pipeline: stage 1 issues the RAM read, stage 2 waits for tile_data, stage 3 forms glyph_addr
  always_ff @(posedge clk) begin
    if (reset) begin
      tile_addr_q  <= '0;
      px1_q        <= '0;
      act1_q       <= 1'b0;
      px2_q        <= '0;
      act2_q       <= 1'b0;
      glyph_addr_q <= '0;
    end else begin
      tile_addr_q  <= tile_addr_d;
      px1_q        <= {vcount[3:0], hcount[3:0]};
      act1_q       <= act_d;
      px2_q        <= px1_q;
      act2_q       <= act1_q;
      glyph_addr_q <= glyph_addr_d;
    end
  end
  // count vsync falling edges and flip the blink phase only at frame boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q       <= 1'b1;
      frame_q    <= '0;
      blink_on_q <= 1'b1;
    end else begin
      vs_q <= vsync_in;
      if (vs_q && !vsync_in) begin
        frame_q    <= wrap ? '0 : frame_q + 1'b1;
        blink_on_q <= wrap ? !blink_on_q : blink_on_q;
      end
    end
  end
  assign tile_addr  = tile_addr_q;
  assign glyph_addr = glyph_addr_q;
  sideband_delay #(.W(2), .D(PIPE_DELAY)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .rst_val_i (2'b01),
    .d_i       ({hsync_in, vsync_in}),
    .q_o       ({hsync_out, vsync_out})
  );
  sideband_delay #(.W(2), .D(PIPE_DELAY)) u_flags (
    .clk       (clk),
    .reset     (reset),
    .rst_val_i (2'b00),
    .d_i       ({act_d, hit_d}),
    .q_o       ({active_out, cursor_hit})
  );
endmodule

// File: doc/glyph_fetch.md
Name: glyph_fetch

Overview:
- Upstream address stage for glyph_rom.
- Takes the current pixel coordinate from the VGA timing generator and reads the tile (character) index from an external tile-map RAM.
- Forms the 17-bit glyph_addr for glyph_rom, and delays sync/active/cursor flags so they line up with glyph_pixel at the glyph_rom output.
- Sits between the VGA timing generator and glyph_rom; the colour mixer consumes glyph_pixel plus this block's delayed flags.

Parameters:
- H_TILES, 40, tiles per row (640 px / 16).
- V_TILES, 30, tile rows (480 px / 16).
- BLINK_FRAMES, 30, frames per cursor blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hcount  in  10  pixel x from timing generator.
- vcount  in  10  pixel y from timing generator.
- active_in  in  1  visible-region flag for (hcount, vcount).
- hsync_in  in  1  horizontal sync, timing-generator polarity.
- vsync_in  in  1  vertical sync, active-low.
- cursor_en  in  1  cursor display enable.
- cursor_col  in  6  cursor tile column.
- cursor_row  in  5  cursor tile row.
- tile_addr  out  11  tile-map RAM read address.
- tile_data  in  8  tile index; valid 1 clk after tile_addr (registered RAM).
- glyph_addr  out  17  address to glyph_rom.
- hsync_out  out  1  hsync_in delayed 4 clk.
- vsync_out  out  1  vsync_in delayed 4 clk.
- active_out  out  1  qualified active delayed 4 clk.
- cursor_hit  out  1  pixel lies in the blinking cursor cell; delayed 4 clk.

Behaviour:
- Pipeline advances every clk; no stalls. Total alignment latency is 4 clk from the input sample to glyph_rom's glyph_pixel.
- Cycle N: inputs sampled.
- Stage 1 (registered at N+1):
  - tile_addr = vcount[9:4]*40 + hcount[9:4], computed as (r<<5)+(r<<3)+c, 11 bits, max 1199.
  - Also registered: hcount[3:0], vcount[3:0], qualified active, syncs, cursor match.
- Stage 2 (N+2): tile_data arrives from the RAM; the stage-1 sidebands advance one register.
- Stage 3 (N+3): glyph_addr = {1'b0, tile_data, vrow[3:0], hcol[3:0]}. glyph_rom adds 1 clk → glyph_pixel valid at N+4.
- Sideband delays: hsync_out, vsync_out, active_out and cursor_hit are each a 4-deep shift register.
- Qualified active = active_in AND hcount<640 AND vcount<480.
  - When inactive, stage-1 tile_addr = 0.
  - When inactive, stage-3 glyph_addr = 0. Glyph 0 is the reserved blank glyph.
- Cursor match = cursor_en AND hcount[9:4]==cursor_col AND vcount[9:4]==cursor_row AND qualified active. cursor_hit = match AND blink_on.
- Blink:
  - The frame counter increments on each vsync_in falling edge, detected against a registered copy of vsync_in.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 and blink_on toggles.
  - Blink state changes only at frame edges, so there is no mid-frame tearing.
- Out-of-range cursor (col≥40 or row≥30): never matches. No error is reported.
- Reset:
  - All pipeline registers, tile_addr, glyph_addr, hsync_out, active_out and cursor_hit go to 0.
  - vsync_out resets to 1 (inactive).
  - Frame counter resets to 0; blink_on resets to 1.
  - Reset mid-frame flushes the pipeline. Outputs resume valid 4 clk after reset deasserts. Garbage is never emitted because the flushed stages read as inactive.
- Simultaneous reset and vsync edge: reset wins and the counter stays 0.

Decomposition:
- Shared package vga_pkg:
  - constants H_VISIBLE=640, V_VISIBLE=480, GLYPH_W=16, PIPE_DELAY=4, TILE_ADDR_W=11, GLYPH_ADDR_W=17.
  - helper function for the tile_addr multiply-by-40.
- One natural sub-module: sideband_delay, a parameterised width × depth shift register with reset value input. It is instantiated for the syncs, active and cursor flags.
- Blink logic stays inline.

Test Plan:
- Tile lookup and alignment:
  - Stimulus: hcount=37, vcount=18, active=1, with the RAM model returning 8'h41 for address 42.
  - Required response: tile_addr=42 at N+1; glyph_addr=17'h04125 at N+3; active_out=1 at N+4.
- Blank region:
  - Stimulus: active_in=0, or hcount=700 with active_in=1.
  - Required response: glyph_addr=0 and active_out=0 after 4 clk.
- Corner tile:
  - Stimulus: hcount=639, vcount=479.
  - Required response: tile_addr=1199 with no overflow; glyph row/col bits = F/F.
- Sync delay:
  - Stimulus: a one-clk hsync_in pulse.
  - Required response: hsync_out shows an identical pulse exactly 4 clk later. vsync_out stays 1 through reset.
- Cursor blink:
  - Stimulus: cursor (5,3), cursor_en=1, scanning pixel (85,50), apply 30 vsync falling edges.
  - Required response: cursor_hit=1 before the 30th edge and 0 after; it returns to 1 after 60 edges.
- Reset mid-frame:
  - Stimulus: assert reset while active_in=1.
  - Required response: all outputs zero next clk (vsync_out=1); after release, the first valid active_out appears 4 clk later.
